// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Transmit half of the UART-to-APB bridge. Serialises one parallel word onto
// the UART line as: start bit (0), DATA_WIDTH data bits LSB first, an optional
// parity bit, and a stop bit (1). Each bit lasts P clock cycles, where P is the
// prescale value captured when the word is accepted (P = 0 behaves as P = 1).
//
// Ports:
//   clk        oversampled UART clock, rising-edge logic
//   rst        asynchronous active-low reset
//   p_data     word to transmit, captured on accept
//   data_valid transmit request, only honoured while idle
//   par_en     1 = insert a parity bit, captured on accept
//   par_typ    0 = even parity, 1 = odd parity, captured on accept
//   prescale   clock cycles per bit, captured on accept
//   tx_out     serial line, idles high (registered)
//   busy       high while a frame is on the line (registered)
//   data_ack   one-cycle pulse in the first start-bit cycle (registered)
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy,
    output logic                      data_ack
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                    state_r;
    state_t                    next_state_s;
    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic [PRESCALE_WIDTH-1:0] cnt_next_s;
    logic [PRESCALE_WIDTH-1:0] last_cnt_r;   // P-1 of the frame in flight
    logic [BIT_W-1:0]          bit_idx_r;
    logic [BIT_W-1:0]          bit_next_s;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic [DATA_WIDTH-1:0]     shift_next_s;
    logic                      par_en_r;
    logic                      par_bit_r;
    logic                      load_s;
    logic                      bit_end_s;
    logic                      tx_next_s;
    logic                      busy_next_s;
    logic                      ack_next_s;

    assign bit_end_s = (cnt_r == last_cnt_r);

    // Next-state, counter and shift-register update for the frame sequencer.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        bit_next_s   = bit_idx_r;
        shift_next_s = shift_r;
        load_s       = 1'b0;
        ack_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_valid) begin
                    next_state_s = ST_START;
                    load_s       = 1'b1;
                    ack_next_s   = 1'b1;
                    shift_next_s = p_data;
                    cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                    bit_next_s   = {BIT_W{1'b0}};
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    next_state_s = ST_DATA;
                    cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                    bit_next_s   = {BIT_W{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + PRESCALE_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                    shift_next_s = shift_r >> 1'b1;
                    if (bit_idx_r == LAST_BIT) begin
                        next_state_s = par_en_r ? ST_PARITY : ST_STOP;
                        bit_next_s   = {BIT_W{1'b0}};
                    end else begin
                        bit_next_s = bit_idx_r + BIT_W'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r + PRESCALE_WIDTH'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    next_state_s = ST_STOP;
                    cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + PRESCALE_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                end else begin
                    cnt_next_s = cnt_r + PRESCALE_WIDTH'(1);
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = {PRESCALE_WIDTH{1'b0}};
                bit_next_s   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Line level and busy for the cycle after this edge, derived from the next
    // state so that the outputs can be registered without a cycle of lag.
    always_comb begin
        tx_next_s   = 1'b1;
        busy_next_s = (next_state_s != ST_IDLE);
        case (next_state_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = par_bit_r;
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Sequencer state, counters and data path registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {PRESCALE_WIDTH{1'b0}};
            bit_idx_r <= {BIT_W{1'b0}};
            shift_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            bit_idx_r <= bit_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Per-frame configuration captured on accept; zero prescale maps to one cycle per bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
        end else if (load_s) begin
            last_cnt_r <= (prescale == {PRESCALE_WIDTH{1'b0}}) ? {PRESCALE_WIDTH{1'b0}}
                                                               : prescale - PRESCALE_WIDTH'(1);
            par_en_r   <= par_en;
            par_bit_r  <= parity_bit(p_data, par_typ);
        end else begin
            last_cnt_r <= last_cnt_r;
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
        end
    end

    // Registered outputs; the line goes high as soon as reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            data_ack <= 1'b0;
        end else begin
            tx_out   <= tx_next_s;
            busy     <= busy_next_s;
            data_ack <= ack_next_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Expected line waveforms come from
// a frame model that lists the frame bits and repeats each one P times.
module tb_uart_tx_serializer;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       tx_out;
    logic       busy;
    logic       data_ack;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
        .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
        .tx_out(tx_out), .busy(busy), .data_ack(data_ack)
    );

    always #5 clk = ~clk;

    // Reference model: per-cycle line level of one whole frame.
    function automatic bitq_t build_frame(input logic [7:0] d, input bit pe, input bit pt, input int ps);
        bitq_t q;
        int    p;
        int    ones;
        bit    par;
        p    = (ps == 0) ? 1 : ps;
        ones = 0;
        for (int b = 0; b < 8; b++) ones += d[b] ? 1 : 0;
        // even parity: bit set when the data holds an odd number of ones
        par  = pt ? (ones % 2 == 0) : (ones % 2 == 1);
        q    = {};
        for (int i = 0; i < p; i++) q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < p; i++) q.push_back(d[b]);
        if (pe)
            for (int i = 0; i < p; i++) q.push_back(par);
        for (int i = 0; i < p; i++) q.push_back(1'b1);
        return q;
    endfunction

    // Request one frame at the current falling edge and follow it to the idle cycle.
    // change_at >= 0 rewrites all configuration inputs at that frame cycle.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input logic [5:0] ps, input int change_at, input string name);
        bitq_t exp_q;
        exp_q      = build_frame(d, pe, pt, int'(ps));
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == change_at) begin
                p_data   = 8'hFF;
                par_en   = 1'b1;
                par_typ  = ~pt;
                prescale = 6'd32;
            end
            vectors++;
            if (tx_out !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, tx_out, exp_q[k]);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, k, busy);
            end
            vectors++;
            if (data_ack !== ((k == 0) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL %s ack cycle %0d: got %b expected %b", name, k, data_ack, (k == 0));
            end
            @(negedge clk);
        end
        vectors++;
        if ({tx_out, busy, data_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s idle after frame: got tx/busy/ack %b expected 100", name, {tx_out, busy, data_ack});
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx_out, busy, data_ack} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset hold cycle %0d: got tx/busy/ack %b expected 100", i, {tx_out, busy, data_ack});
            end
        end
        rst = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 6'd8, -1, "reset_release");
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 6'd8, -1, "basic_a5");
    endtask

    task automatic test_parity();
        send_frame(8'h03, 1'b1, 1'b0, 6'd16, -1, "par_03_even");
        send_frame(8'h03, 1'b1, 1'b1, 6'd16, -1, "par_03_odd");
        send_frame(8'h07, 1'b1, 1'b0, 6'd16, -1, "par_07_even");
        send_frame(8'h07, 1'b1, 1'b1, 6'd16, -1, "par_07_odd");
    endtask

    task automatic test_midframe();
        // frame cycles 32..39 are data bit 3 at P = 8
        send_frame(8'h96, 1'b0, 1'b0, 6'd8, 35, "midframe_cur");
        send_frame(8'hFF, 1'b1, 1'b1, 6'd32, -1, "midframe_next");
    endtask

    task automatic test_back_to_back();
        bitq_t exp1;
        bitq_t exp2;
        int    ack_at[$];
        int    cyc;
        exp1       = build_frame(8'h55, 1'b0, 1'b0, 8);
        exp2       = build_frame(8'h0F, 1'b0, 1'b0, 8);
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd8;
        data_valid = 1'b1;
        cyc        = 0;
        @(negedge clk);
        for (int k = 0; k < exp1.size(); k++) begin
            if (k == 10) p_data = 8'h0F;
            vectors++;
            if (tx_out !== exp1[k] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b frame1 cycle %0d: got tx/busy %b%b expected %b1", k, tx_out, busy, exp1[k]);
            end
            if (data_ack === 1'b1) ack_at.push_back(cyc);
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if ({tx_out, busy, data_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b gap: got tx/busy/ack %b expected 100", {tx_out, busy, data_ack});
        end
        cyc++;
        @(negedge clk);
        for (int k = 0; k < exp2.size(); k++) begin
            if (k == 10) data_valid = 1'b0;
            vectors++;
            if (tx_out !== exp2[k] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b frame2 cycle %0d: got tx/busy %b%b expected %b1", k, tx_out, busy, exp2[k]);
            end
            if (data_ack === 1'b1) ack_at.push_back(cyc);
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if ({tx_out, busy, data_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b end idle: got tx/busy/ack %b expected 100", {tx_out, busy, data_ack});
        end
        vectors++;
        if (ack_at.size() != 2) begin
            miscompares++;
            $display("FAIL b2b ack count: got %0d expected 2", ack_at.size());
        end else begin
            vectors++;
            if (ack_at[1] - ack_at[0] != 81) begin
                miscompares++;
                $display("FAIL b2b ack spacing: got %0d expected 81", ack_at[1] - ack_at[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        bitq_t      exp_q;
        logic [7:0] d;
        d          = 8'($urandom);
        exp_q      = build_frame(d, 1'b1, 1'b0, 8);
        p_data     = d;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        prescale   = 6'd8;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        // parity bit occupies cycles 72..79; cut in at cycle 74
        for (int k = 0; k <= 74; k++) begin
            vectors++;
            if (tx_out !== exp_q[k]) begin
                miscompares++;
                $display("FAIL async_pre tx cycle %0d: got %b expected %b", k, tx_out, exp_q[k]);
            end
            if (k != 74) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({tx_out, busy, data_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL async_reset immediate: got tx/busy/ack %b expected 100", {tx_out, busy, data_ack});
        end
        @(negedge clk);
        vectors++;
        if ({tx_out, busy, data_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL async_reset held: got tx/busy/ack %b expected 100", {tx_out, busy, data_ack});
        end
        rst = 1'b1;
        @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 6'd8, -1, "async_after_3c");
    endtask

    task automatic test_random();
        send_frame(8'($urandom), 1'b1, 1'($urandom), 6'd0, -1, "rand_p0");
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       6'($urandom_range(1, 12)), -1, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_midframe();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the UART-to-APB bridge.
- Takes a parallel byte from the APB-side response path and serialises it onto the UART line: start bit, LSB-first data, optional parity, stop bit.
- Runs on the same oversampled clock as the receive path. Each bit is held for `prescale` clock cycles, so the prescale value configured for RX gives matching baud timing on TX.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input.

Ports:
- clk  input  1  oversampled UART clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- p_data  input  DATA_WIDTH  byte to transmit; sampled only on accept.
- data_valid  input  1  request to send p_data.
- par_en  input  1  1 = parity bit inserted; sampled on accept.
- par_typ  input  1  0 = even parity, 1 = odd parity; sampled on accept.
- prescale  input  PRESCALE_WIDTH  clocks per bit; sampled on accept.
- tx_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- data_ack  output  1  one-cycle pulse on the cycle after a request is accepted.

Behaviour:
- Reset (rst low, any time, including mid-frame):
  - State = IDLE; tx_out = 1; busy = 0; data_ack = 0.
  - Bit counter and cycle counter cleared; shift register cleared.
  - Line returns high asynchronously.
- Outputs: all registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - Occurs in IDLE at a rising edge where data_valid = 1.
  - Latches p_data, par_en, par_typ and prescale.
  - Next cycle: state = START, tx_out = 0, busy = 1, data_ack = 1 for exactly that cycle.
  - data_valid is ignored in every state other than IDLE; no queuing.
- Bit timing:
  - A cycle counter runs 0..P-1 within each bit, where P is the latched prescale.
  - The bit ends when the counter = P-1; the counter then wraps to 0 and the state/bit advances.
  - Latched P = 0 is treated as P = 1. Legal operating values are 8, 16 and 32; any value 1..63 must still produce exact P-cycle bits.
  - prescale changes mid-frame have no effect.
- Transitions:
  - START → DATA after P cycles.
  - DATA holds tx_out = data[i] for P cycles, i = 0..DATA_WIDTH-1, LSB first.
  - After bit DATA_WIDTH-1: go to PARITY if latched par_en = 1, else STOP.
  - PARITY → STOP after P cycles.
  - STOP holds tx_out = 1 for P cycles, then goes to IDLE.
- Parity bit: XOR-reduce of the latched data when par_typ = 0 (even); inverted XOR-reduce when par_typ = 1 (odd).
- busy:
  - Asserted from the first START cycle through the last STOP cycle.
  - Deasserts on the cycle the FSM enters IDLE.
  - Frame length in busy cycles = P × (2 + DATA_WIDTH + par_en).
- Back-to-back: a new request can be accepted at the first IDLE edge. Minimum one IDLE cycle (tx_out = 1) between frames, so the gap between frames is ≥ 1 cycle.
- Simultaneous events:
  - data_valid held high continuously gives frame, one idle cycle, next frame, and so on; data_ack pulses once per frame.
  - data_valid asserted in the last STOP cycle is not accepted; it must still be high at the following IDLE edge.
- Counter widths: cycle counter is PRESCALE_WIDTH bits; bit index is ceil(log2(DATA_WIDTH)) bits; no overflow for P ≤ 63.

Test Plan:
- Reset: hold rst low 5 cycles with data_valid = 1 → tx_out = 1, busy = 0, data_ack = 0. Release → accept on first edge, data_ack pulses once.
- Basic frame: p_data = 0xA5, par_en = 0, prescale = 8 → tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles. busy high 80 cycles; one data_ack pulse.
- Parity: p_data = 0x03, prescale = 16:
  - par_typ = 0 → parity bit 0.
  - par_typ = 1 → parity bit 1.
  - busy = 176 cycles in each case.
  - Repeat with p_data = 0x07: even → 1, odd → 0.
- Mid-frame changes: during DATA bit 3, change prescale 8 → 32, p_data to 0xFF, and par_en to 1 → current frame unchanged, 80 cycles, no parity bit. Next accepted frame uses the new values.
- Back-to-back: data_valid held high, bytes 0x55 then 0x0F, prescale = 8 → exactly one idle-high cycle between frames; two data_ack pulses 81 cycles apart.
- Async reset mid-frame: assert rst during parity bit, off-edge → tx_out = 1 and busy = 0 immediately, before the next clk edge. After release, a new 0x3C frame transmits correctly.
